// File: rtl/pad_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pad_ctrl_pkg
//   Shared definitions for the half-duplex pad controller: the controller
//   state encoding, the default timing constants and a small helper that
//   says which states own the pad.
// ----------------------------------------------------------------------------
package pad_ctrl_pkg;

    // Default timing constants (clocks).
    localparam int DEF_BIT_CYCLES     = 4;
    localparam int DEF_TURN_CYCLES    = 2;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_START,
        ST_TX_DATA,
        ST_TX_STOP,
        ST_RX_WAIT,
        ST_RX_START,
        ST_RX_DATA,
        ST_RX_STOP,
        ST_TURN
    } pad_state_e;

    // Only the three transmit states drive the pad; all others release it.
    function automatic logic state_drives_pad(input pad_state_e s);
        return (s == ST_TX_START) || (s == ST_TX_DATA) || (s == ST_TX_STOP);
    endfunction

endpackage

// File: rtl/pad_sync.sv
// ----------------------------------------------------------------------------
// pad_sync
//   Two-flop synchronizer for the asynchronous pad input. Both flops reset
//   to 1, the idle level of the serial line, so a reset never looks like a
//   start bit.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous active-high reset
//   i_async  in   raw pad DI
//   o_sync   out  synchronized DI, two clocks of latency
// ----------------------------------------------------------------------------
module pad_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/half_duplex_pad_ctrl.sv
// ----------------------------------------------------------------------------
// half_duplex_pad_ctrl
//   Drives one bidirectional pad as a half-duplex serial link. A transaction
//   either transmits one byte (start 0, 8 data bits LSB-first, stop 1) with
//   the pad output enabled, or receives one byte with the pad released. Every
//   transaction ends with a bus-release turnaround before the next accept.
//
// Ports
//   clk, reset       clock, synchronous active-high reset
//   tx_valid/tx_data transmit request and byte
//   rx_req           receive request (loses to tx_valid when both are set)
//   tx_ready         accept strobe, high only in IDLE outside reset
//   rx_valid         one-cycle pulse with rx_data/rx_err on receive done
//   rx_data          last received byte, held between rx_valid pulses
//   rx_err           stop bit sampled low, qualified by rx_valid
//   rx_timeout       one-cycle pulse when no start bit arrived in time
//   pad_do/pad_oen   pad cell data out / output enable (1 = driven)
//   pad_di           pad cell data in, asynchronous
// ----------------------------------------------------------------------------
module half_duplex_pad_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int BIT_CYCLES     = DEF_BIT_CYCLES,
    parameter int TURN_CYCLES    = DEF_TURN_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    input  logic       rx_req,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_err,
    output logic       rx_timeout,
    output logic       pad_do,
    output logic       pad_oen,
    input  logic       pad_di
);

    // The bit counter is shared with the turnaround, so size it for the
    // longer of the two.
    localparam int CNT_MAX = (BIT_CYCLES > TURN_CYCLES) ? BIT_CYCLES : TURN_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    pad_state_e       r_state;
    pad_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_sh;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_rx_err;
    logic             r_rx_timeout;

    logic w_di;
    logic w_tx_ready;
    logic w_accept;
    logic w_bit_end;
    logic w_half_end;
    logic w_turn_end;
    logic w_tmo_hit;
    logic w_cnt_wrap;
    logic w_rx_done;
    logic w_pad_oen;
    logic w_pad_do;

    pad_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_async (pad_di),
        .o_sync  (w_di)
    );

    assign w_accept   = w_tx_ready && (tx_valid || rx_req);
    assign w_bit_end  = (r_cnt == BIT_LAST);
    assign w_half_end = (r_cnt == HALF_LAST);
    assign w_turn_end = (r_cnt == TURN_LAST);
    assign w_tmo_hit  = (r_tmo == TMO_LAST);
    assign w_rx_done  = (r_state == ST_RX_STOP) && w_bit_end;

    // TURN may be longer than a bit, so the per-bit wrap is suppressed there.
    assign w_cnt_wrap = w_bit_end && (r_state != ST_TURN);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:
                if (w_accept) w_next = tx_valid ? ST_TX_START : ST_RX_WAIT;
            ST_TX_START:
                if (w_bit_end) w_next = ST_TX_DATA;
            ST_TX_DATA:
                if (w_bit_end && (r_bit == 3'd7)) w_next = ST_TX_STOP;
            ST_TX_STOP:
                if (w_bit_end) w_next = ST_TURN;
            // A low line wins over an expiring timeout in the same cycle.
            ST_RX_WAIT:
                if (!w_di)          w_next = ST_RX_START;
                else if (w_tmo_hit) w_next = ST_TURN;
            // Mid-start-bit recheck: a line back at 1 was only a glitch.
            ST_RX_START:
                if (w_half_end) w_next = w_di ? ST_RX_WAIT : ST_RX_DATA;
            ST_RX_DATA:
                if (w_bit_end && (r_bit == 3'd7)) w_next = ST_RX_STOP;
            ST_RX_STOP:
                if (w_bit_end) w_next = ST_TURN;
            ST_TURN:
                if (w_turn_end) w_next = ST_IDLE;
            default:
                w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_tx_ready = (r_state == ST_IDLE) && !reset;
        w_pad_oen  = state_drives_pad(r_state);
        w_pad_do   = 1'b1;
        case (r_state)
            ST_TX_START: w_pad_do = 1'b0;
            ST_TX_DATA:  w_pad_do = r_sh[0];
            default:     w_pad_do = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Timing counters
    // ------------------------------------------------------------------
    // r_cnt restarts on every state change and every bit boundary, so it
    // always counts clocks within the current bit (or turnaround).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_bit <= '0;
        end else begin
            if ((w_next != r_state) || w_cnt_wrap) r_cnt <= '0;
            else                                   r_cnt <= r_cnt + 1'b1;

            if (w_next != r_state)
                r_bit <= '0;
            else if (((r_state == ST_TX_DATA) || (r_state == ST_RX_DATA)) && w_bit_end)
                r_bit <= r_bit + 1'b1;
        end
    end

    // The receive timeout only advances while the line idles in RX_WAIT;
    // a rejected glitch resumes the count instead of restarting it.
    always_ff @(posedge clk) begin
        if (reset)
            r_tmo <= '0;
        else if (w_accept)
            r_tmo <= '0;
        else if ((r_state == ST_RX_WAIT) && w_di)
            r_tmo <= r_tmo + 1'b1;
    end

    // ------------------------------------------------------------------
    // Shift register: transmit byte out of bit 0, receive bits in at bit 7
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset)
            r_sh <= '0;
        else if (w_accept && tx_valid)
            r_sh <= tx_data;
        else if ((r_state == ST_TX_DATA) && w_bit_end)
            r_sh <= {1'b1, r_sh[7:1]};
        else if ((r_state == ST_RX_DATA) && w_bit_end)
            r_sh <= {w_di, r_sh[7:1]};
    end

    // ------------------------------------------------------------------
    // Receive results, registered so rx_data is already valid alongside
    // the rx_valid pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_valid   <= 1'b0;
            r_rx_err     <= 1'b0;
            r_rx_timeout <= 1'b0;
            r_rx_data    <= 8'h00;
        end else begin
            r_rx_valid   <= w_rx_done;
            r_rx_err     <= w_rx_done && !w_di;
            r_rx_timeout <= (r_state == ST_RX_WAIT) && w_di && w_tmo_hit;
            if (w_rx_done) r_rx_data <= r_sh;
        end
    end

    assign tx_ready   = w_tx_ready;
    assign pad_oen    = w_pad_oen;
    assign pad_do     = w_pad_do;
    assign rx_valid   = r_rx_valid;
    assign rx_err     = r_rx_err;
    assign rx_timeout = r_rx_timeout;
    assign rx_data    = r_rx_data;

endmodule

// File: tb/tb_half_duplex_pad_ctrl.sv
module tb_half_duplex_pad_ctrl;

    localparam int BC  = 4;
    localparam int TC  = 2;
    localparam int TMO = 1024;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       rx_req = 1'b0;
    logic       pad_di = 1'b1;
    logic       tx_ready, rx_valid, rx_err, rx_timeout, pad_do, pad_oen;
    logic [7:0] rx_data;

    half_duplex_pad_ctrl #(
        .BIT_CYCLES     (BC),
        .TURN_CYCLES    (TC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .rx_req     (rx_req),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_err     (rx_err),
        .rx_timeout (rx_timeout),
        .pad_do     (pad_do),
        .pad_oen    (pad_oen),
        .pad_di     (pad_di)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // per-transaction observations gathered by step()
    int         nv, nt, noen, nstray;
    logic [7:0] got_d;
    logic       got_e;

    typedef struct {
        logic       is_tx;
        logic       both;
        logic [7:0] data;
        logic       stop;
        int         dly;
        logic [9:0] exp_line;   // bit k = expected pad_do during serial bit k
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: serial frame bit k of byte d (start, LSB-first data, stop).
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return d[k-1];
    endfunction

    task automatic step();
        @(negedge clk);
        if (rx_valid) begin
            nv++;
            got_d = rx_data;
            got_e = rx_err;
        end
        if (rx_err && !rx_valid) nstray++;
        if (rx_timeout) nt++;
        if (pad_oen) noen++;
    endtask

    task automatic clr_obs();
        nv = 0; nt = 0; noen = 0; nstray = 0; got_d = 8'h00; got_e = 1'b0;
    endtask

    task automatic run_tx(input logic [7:0] d, input logic both, input logic [9:0] line);
        int rx_seen = 0;
        chk("tx_ready_before_tx", {31'd0, tx_ready}, 1);
        tx_valid = 1'b1; tx_data = d; rx_req = both;
        @(negedge clk);
        tx_valid = 1'b0; rx_req = 1'b0; tx_data = 8'($urandom);
        for (int i = 0; i < 10 * BC; i++) begin
            chk("tx_pad_oen_do", {30'd0, pad_oen, pad_do}, {30'd0, 1'b1, line[i / BC]});
            if (rx_valid || rx_timeout) rx_seen++;
            @(negedge clk);
        end
        for (int t = 0; t < TC; t++) begin
            chk("tx_turn_ready_oen_do", {29'd0, tx_ready, pad_oen, pad_do}, 32'b001);
            @(negedge clk);
        end
        chk("tx_ready_after_turn", {31'd0, tx_ready}, 1);
        chk("tx_no_rx_activity", rx_seen, 0);
    endtask

    task automatic run_rx(input logic [7:0] d, input logic stop, input int dly,
                          input logic [7:0] exp_d, input logic exp_e);
        logic b;
        clr_obs();
        chk("rx_ready_before_rx", {31'd0, tx_ready}, 1);
        rx_req = 1'b1;
        step();
        rx_req = 1'b0;
        repeat (dly) step();
        for (int k = 0; k < 10; k++) begin
            b = (k == 9) ? stop : frame_bit(d, k);
            pad_di = b;
            repeat (BC) step();
        end
        pad_di = 1'b1;
        for (int w = 0; w < 30 && !tx_ready; w++) step();
        chk("rx_back_to_idle", {31'd0, tx_ready}, 1);
        chk("rx_valid_pulses", nv, 1);
        chk("rx_data", {24'd0, got_d}, {24'd0, exp_d});
        chk("rx_err", {31'd0, got_e}, {31'd0, exp_e});
        chk("rx_data_held", {24'd0, rx_data}, {24'd0, exp_d});
        chk("rx_no_timeout", nt, 0);
        chk("rx_pad_oen_cycles", noen, 0);
        chk("rx_err_unqualified", nstray, 0);
    endtask

    // rx_req with an idle-high line; optional 1-clock low glitch at cycle 10.
    task automatic run_timeout(input logic glitch);
        int c;
        clr_obs();
        pad_di = 1'b1;
        rx_req = 1'b1;
        step();
        rx_req = 1'b0;
        c = 1;
        while (nt == 0 && c < 1300) begin
            pad_di = (glitch && c == 10) ? 1'b0 : 1'b1;
            step();
            c++;
        end
        pad_di = 1'b1;
        if (glitch) begin
            chk("glitch_tmo_seen", nt, 1);
            chk("glitch_tmo_window", {31'd0, (c >= TMO + 1) && (c <= TMO + 1 + BC)}, 1);
        end else begin
            chk("tmo_cycle", c, TMO + 1);
        end
        chk("tmo_in_turn_ready", {31'd0, tx_ready}, 0);
        repeat (TC) step();
        chk("tmo_ready_after_turn", {31'd0, tx_ready}, 1);
        chk("tmo_single_pulse", nt, 1);
        chk("tmo_no_rx_valid", nv, 0);
        chk("tmo_pad_oen_cycles", noen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [9:0] line;
        logic       s;

        tbl[0] = '{is_tx: 1'b1, both: 1'b0, data: 8'hA5, stop: 1'b1, dly: 0,
                   exp_line: 10'b1101001010, exp_data: 8'h00, exp_err: 1'b0};
        tbl[1] = '{is_tx: 1'b1, both: 1'b1, data: 8'h3C, stop: 1'b1, dly: 0,
                   exp_line: 10'b1001111000, exp_data: 8'h00, exp_err: 1'b0};
        tbl[2] = '{is_tx: 1'b0, both: 1'b0, data: 8'h3C, stop: 1'b1, dly: 3,
                   exp_line: 10'b0, exp_data: 8'h3C, exp_err: 1'b0};
        tbl[3] = '{is_tx: 1'b0, both: 1'b0, data: 8'hFF, stop: 1'b0, dly: 0,
                   exp_line: 10'b0, exp_data: 8'hFF, exp_err: 1'b1};
        tbl[4] = '{is_tx: 1'b0, both: 1'b0, data: 8'h81, stop: 1'b1, dly: 1,
                   exp_line: 10'b0, exp_data: 8'h81, exp_err: 1'b0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pad_oen", {31'd0, pad_oen}, 0);
        chk("rst_pad_do", {31'd0, pad_do}, 1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 0);
        chk("rst_rx_err", {31'd0, rx_err}, 0);
        chk("rst_rx_timeout", {31'd0, rx_timeout}, 0);
        chk("rst_rx_data", {24'd0, rx_data}, 0);
        chk("rst_tx_ready_in_reset", {31'd0, tx_ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("tx_ready_after_reset", {31'd0, tx_ready}, 1);

        // table vectors
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].is_tx) run_tx(tbl[i].data, tbl[i].both, tbl[i].exp_line);
            else run_rx(tbl[i].data, tbl[i].stop, tbl[i].dly, tbl[i].exp_data, tbl[i].exp_err);
        end

        // timeout, then timeout with a rejected glitch
        run_timeout(1'b0);
        run_timeout(1'b1);

        // randomized transactions against the frame model
        for (int r = 0; r < 8; r++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < 10; k++) line[k] = frame_bit(d, k);
                run_tx(d, 1'($urandom_range(0, 1)), line);
            end else begin
                s = 1'($urandom_range(0, 1));
                run_rx(d, s, $urandom_range(0, 6), d, ~s);
            end
        end

        // reset in the middle of TX_DATA
        clr_obs();
        tx_valid = 1'b1; tx_data = 8'h5A;
        step();
        tx_valid = 1'b0;
        repeat (12) step();
        chk("rst_mid_tx_driving", {31'd0, pad_oen}, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_tx_oen", {31'd0, pad_oen}, 0);
        chk("rst_mid_tx_do", {31'd0, pad_do}, 1);
        chk("rst_mid_tx_rx_valid", {31'd0, rx_valid}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_release_ready", {31'd0, tx_ready}, 1);
        @(negedge clk);
        chk("rst_idle_oen", {31'd0, pad_oen}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
